// File: rtl/defuse_flood_if.sv
// defuse_flood_if: click request, mine map and defused-bitmap bundle
interface defuse_flood_if #(parameter int MAX_DIM = 16, parameter int IDX_W = 5);
  logic [IDX_W-1:0] board_dim;
  logic start;
  logic [IDX_W-1:0] start_x;
  logic [IDX_W-1:0] start_y;
  logic clear;
  logic [MAX_DIM*MAX_DIM-1:0] mine_arr;
  logic [MAX_DIM*MAX_DIM-1:0] defuse_arr;
  logic busy;
  logic done;
  logic mine_hit;
  modport master (output board_dim, start, start_x, start_y, clear, mine_arr,
                  input defuse_arr, busy, done, mine_hit);
  modport slave (input board_dim, start, start_x, start_y, clear, mine_arr,
                 output defuse_arr, busy, done, mine_hit);
endinterface

// File: rtl/defuse_flood.sv
// defuse_flood: stack-based 2D minesweeper flood reveal of the clicked field
module defuse_flood #(
  parameter int MAX_DIM = 16,
  parameter int IDX_W = 5,
  parameter int STACK_DEPTH = MAX_DIM * MAX_DIM
) (
  input logic clk,
  input logic rst,
  defuse_flood_if.slave bus
);
  localparam int N = MAX_DIM * MAX_DIM;
  localparam int AW = $clog2(N);
  localparam int DW = $clog2(STACK_DEPTH);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, CHECK, POP, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] sx_q, sx_d, sy_q, sy_d, cx_q, cx_d, cy_q, cy_d;
  logic [2:0] k_q, k_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [N-1:0] def_q, def_d;
  logic hit_q, hit_d;
  logic [2*IDX_W-1:0] stk_q [STACK_DEPTH];
  logic push;
  logic [2*IDX_W-1:0] push_v;
  logic [IDX_W-1:0] tx, ty, x0, y0, c_x, c_y, s_x, s_y;
  logic c_ok, s_ok, s_new, in_rng;
  logic [3:0] cnt;
  logic [AW-1:0] sidx, nidx;
  function automatic logic [AW-1:0] idx_of(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y);
    return AW'(int'(y) * MAX_DIM + int'(x));
  endfunction
  // neighbour k in raster order skipping the centre; {in_bounds, x, y}
  function automatic logic [2*IDX_W:0] nbr(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y,
                                           input logic [IDX_W-1:0] dim, input logic [2:0] k);
    logic [3:0] p;
    logic [IDX_W:0] ex, ey;
    p = {1'b0, k} + {3'b0, k[2]};
    ex = {1'b0, x} + (IDX_W+1)'(p % 4'd3) - (IDX_W+1)'(1);
    ey = {1'b0, y} + (IDX_W+1)'(p / 4'd3) - (IDX_W+1)'(1);
    return {ex < {1'b0, dim} && ey < {1'b0, dim}, ex[IDX_W-1:0], ey[IDX_W-1:0]};
  endfunction
  always_comb begin
    {tx, ty} = stk_q[DW'(sp_q - SW'(1))];
    cnt = '0;
    for (int k = 0; k < 8; k++) begin
      {c_ok, c_x, c_y} = nbr(tx, ty, bus.board_dim, 3'(k));
      cnt = cnt + 4'(c_ok & bus.mine_arr[idx_of(c_x, c_y)]);
    end
  end
  always_comb begin
    state_d = state_q;
    sx_d = sx_q;
    sy_d = sy_q;
    cx_d = cx_q;
    cy_d = cy_q;
    k_d = k_q;
    sp_d = sp_q;
    def_d = def_q;
    hit_d = hit_q;
    x0 = sx_q - IDX_W'(1);
    y0 = sy_q - IDX_W'(1);
    sidx = idx_of(x0, y0);
    in_rng = sx_q != '0 && sy_q != '0 && sx_q <= bus.board_dim && sy_q <= bus.board_dim;
    {s_ok, s_x, s_y} = nbr(cx_q, cy_q, bus.board_dim, k_q);
    nidx = idx_of(s_x, s_y);
    s_new = s_ok & ~bus.mine_arr[nidx] & ~def_q[nidx];
    push = 1'b0;
    push_v = {s_x, s_y};
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CHECK;
        sx_d = bus.start_x;
        sy_d = bus.start_y;
        hit_d = 1'b0;
      end
      CHECK: if (!in_rng || def_q[sidx]) state_d = DONE;
      else if (bus.mine_arr[sidx]) begin
        hit_d = 1'b1;
        state_d = DONE;
      end else begin
        def_d[sidx] = 1'b1;
        push = 1'b1;
        push_v = {x0, y0};
        state_d = POP;
      end
      POP: if (sp_q == '0) state_d = DONE;
      else begin
        sp_d = sp_q - SW'(1);
        if (cnt == 4'd0) begin
          cx_d = tx;
          cy_d = ty;
          k_d = 3'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (s_new) begin
          def_d[nidx] = 1'b1;
          push = 1'b1;
        end
        k_d = k_q + 3'd1;
        state_d = k_q == 3'd7 ? POP : SCAN;
      end
      default: state_d = IDLE;
    endcase
    if (push) sp_d = sp_q + SW'(1);
    if (bus.clear) begin
      state_d = IDLE;
      def_d = '0;
      sp_d = '0;
      hit_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      sx_q <= '0;
      sy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      k_q <= '0;
      sp_q <= '0;
      def_q <= '0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      k_q <= k_d;
      sp_q <= sp_d;
      def_q <= def_d;
      hit_q <= hit_d;
    end
  always_ff @(posedge clk)
    if (push) stk_q[DW'(sp_q)] <= push_v;
  assign bus.defuse_arr = def_q;
  assign bus.busy = state_q == CHECK || state_q == POP || state_q == SCAN;
  assign bus.done = state_q == DONE;
  assign bus.mine_hit = state_q == DONE && hit_q;
endmodule

// File: tb/tb_defuse_flood.sv
// tb_defuse_flood: random and directed clicks checked against a BFS flood model
module tb_defuse_flood;
  localparam int MD = 16;
  localparam int IW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  defuse_flood_if #(.MAX_DIM(MD), .IDX_W(IW)) bus ();
  defuse_flood #(.MAX_DIM(MD), .IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int dim;
  logic [255:0] mines;
  logic [255:0] exp_def;
  logic [255:0] e;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int adj(input int x, input int y);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int nx = x + dx;
        int ny = y + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && ny >= 0 && nx < dim && ny < dim && mines[ny*MD+nx]) n++;
      end
    return n;
  endfunction
  task automatic model(input int sx, input int sy, output int lat, output bit hit);
    int q[$];
    int k, z, p;
    hit = 0;
    lat = 2;
    if (sx < 1 || sy < 1 || sx > dim || sy > dim) return;
    p = (sy - 1) * MD + sx - 1;
    if (exp_def[p]) return;
    if (mines[p]) begin
      hit = 1;
      return;
    end
    exp_def[p] = 1'b1;
    q.push_back(p);
    k = 1;
    z = 0;
    while (q.size() > 0) begin
      int x, y;
      p = q.pop_front();
      x = p % MD;
      y = p / MD;
      if (adj(x, y) == 0) begin
        z++;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx = x + dx;
            int ny = y + dy;
            if (nx >= 0 && ny >= 0 && nx < dim && ny < dim && !mines[ny*MD+nx] && !exp_def[ny*MD+nx]) begin
              exp_def[ny*MD+nx] = 1'b1;
              q.push_back(ny * MD + nx);
              k++;
            end
          end
      end
    end
    lat = 3 + k + 8 * z;
  endtask
  task automatic run(input int sx, input int sy, input string tag);
    int lat, c;
    bit hit, bok;
    model(sx, sy, lat, hit);
    bus.start_x = IW'(sx);
    bus.start_y = IW'(sy);
    bus.start = 1'b1;
    c = 0;
    bok = 1;
    do begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      if (bus.done == bus.busy) bok = 0;
    end while (!bus.done && c < 3000);
    chk({tag, ".lat"}, c, lat);
    chk({tag, ".hit"}, bus.mine_hit, hit);
    chk({tag, ".def"}, bus.defuse_arr, exp_def);
    chk({tag, ".busy"}, bok, 1);
    @(negedge clk);
    chk({tag, ".pulse"}, {bus.done, bus.mine_hit, bus.busy}, 0);
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    exp_def = '0;
    chk("clear", bus.defuse_arr, 0);
  endtask
  task automatic set_board(input int d);
    dim = d;
    bus.board_dim = IW'(d);
    bus.mine_arr = mines;
  endtask
  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.start_x = '0;
    bus.start_y = '0;
    bus.board_dim = '0;
    bus.mine_arr = '0;
    mines = '0;
    exp_def = '0;
    dim = 0;
    repeat (3) @(negedge clk);
    chk("rst.def", bus.defuse_arr, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.hit", bus.mine_hit, 0);
    rst = 1'b0;
    @(negedge clk);
    mines = '0;
    mines[2*MD+2] = 1'b1;
    set_board(8);
    run(3, 3, "mine");
    do_clear();
    mines = '0;
    mines[0] = 1'b1;
    set_board(8);
    run(2, 2, "num");
    e = '0;
    e[1*MD+1] = 1'b1;
    chk("num.bit", bus.defuse_arr, e);
    run(2, 2, "rep");
    do_clear();
    mines = '0;
    set_board(8);
    run(5, 5, "open8");
    e = '0;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) e[y*MD+x] = 1'b1;
    chk("open8.bits", bus.defuse_arr, e);
    do_clear();
    mines = '0;
    for (int y = 0; y < 10; y++) mines[y*MD+4] = 1'b1;
    mines[15] = 1'b1;
    mines[12*MD+2] = 1'b1;
    set_board(10);
    run(1, 1, "wall");
    e = '0;
    for (int y = 0; y < 10; y++) for (int x = 0; x < 4; x++) e[y*MD+x] = 1'b1;
    chk("wall.bits", bus.defuse_arr, e);
    do_clear();
    mines = '0;
    set_board(16);
    bus.start_x = IW'(16);
    bus.start_y = IW'(16);
    bus.start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      bus.start = (c == 10);
      bus.clear = (c == 20);
    end
    exp_def = '0;
    chk("abort.def", bus.defuse_arr, 0);
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", seen, 0);
    run(1, 1, "refill");
    chk("refill.all", bus.defuse_arr, {256{1'b1}});
    for (int b = 0; b < 16; b++) begin
      int dens;
      do_clear();
      dens = $urandom_range(0, 30);
      for (int i = 0; i < 256; i++) mines[i] = ($urandom_range(0, 99) < dens);
      set_board($urandom_range(2, 16));
      for (int r = 0; r < 4; r++) run($urandom_range(0, dim + 1), $urandom_range(0, dim + 1), "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/defuse_flood.md
Name: defuse_flood

Overview:
- Parametrised 2D flood-fill defuse engine. Successor to the row-only defuse logic.
- On one click it reveals the clicked field. If that field has zero adjacent mines, it reveals the whole connected zero region plus that region's numbered border, as in classic minesweeper.
- It sits between the mouse/click decoder and the board redraw logic, and drives the defused-field bitmap for any board size up to MAX_DIM.

Parameters:
- MAX_DIM, 16, largest supported board edge length in fields.
- IDX_W, 5, width of a field coordinate; must satisfy 2^IDX_W > MAX_DIM.
- STACK_DEPTH, MAX_DIM*MAX_DIM, depth of the internal pending-field stack.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- board_dim  in  IDX_W  active board edge length, 2..MAX_DIM; held stable while busy.
- start  in  1  one-cycle request to defuse field (start_x, start_y).
- start_x  in  IDX_W  1-based column of the clicked field.
- start_y  in  IDX_W  1-based row of the clicked field.
- clear  in  1  new game: wipe defuse_arr and abort any flood.
- mine_arr  in  MAX_DIM*MAX_DIM  mine map, bit index y*MAX_DIM+x with 0-based x,y.
- defuse_arr  out  MAX_DIM*MAX_DIM  defused bitmap, same indexing as mine_arr.
- busy  out  1  high in CHECK, POP and SCAN.
- done  out  1  one-cycle pulse when a request completes.
- mine_hit  out  1  one-cycle pulse, coincident with done, when the clicked field is a mine.

Behaviour:
- Reset: defuse_arr=0, busy=0, done=0, mine_hit=0, stack empty, state IDLE.
- Coordinates: inputs are 1-based and are converted internally to x0=start_x-1, y0=start_y-1.
  - A request is out of range if start_x==0, start_y==0, start_x>board_dim or start_y>board_dim.
- Adjacency count: combinational popcount of the 8 neighbours' mine bits. Only neighbours with 0<=x,y<board_dim are counted. Mine bits outside the active board are ignored everywhere.
- FSM states: IDLE, CHECK, POP, SCAN, DONE.
- IDLE: start moves the FSM to CHECK next cycle and latches the coordinates. start in any other state is ignored, not queued.
- CHECK (one cycle):
  - Out of range, or field already defused: go to DONE with no change.
  - Field is a mine: go to DONE with mine_hit set, and defuse_arr unchanged.
  - Otherwise: set the field's defuse bit, push it, go to POP.
- POP:
  - Stack empty: go to DONE.
  - Otherwise pop the top entry. If its count==0, go to SCAN with a neighbour index of 0; else stay in POP.
- SCAN: 8 cycles, one neighbour per cycle, in order (dx,dy) = (-1,-1), (0,-1), (+1,-1), (-1,0), (+1,0), (-1,+1), (0,+1), (+1,+1).
  - A neighbour that is in bounds, not a mine and not defused gets its defuse bit set and is pushed in the same cycle.
  - After the 8th neighbour, go to POP.
- Marking at push time means each field is pushed at most once. Stack occupancy is therefore <= board_dim^2 <= STACK_DEPTH, and overflow cannot occur.
- DONE (one cycle): done=1, and mine_hit=1 if set in CHECK; busy=0. Return to IDLE.
- Latency, start sampled at cycle N:
  - No-change or mine case: done at N+2.
  - Single numbered field: done at N+4.
  - Flood of K fields, of which Z are zero-count: done at N+3+K+8Z.
- clear (any state, priority over start in the same cycle): next cycle defuse_arr=0, stack empty, state IDLE. No done or mine_hit pulse is generated for an aborted flood.
- rst mid-flood: identical to reset, with no pulses.
- defuse_arr bits are only ever set by CHECK/SCAN and only ever cleared by clear or rst. Bits outside the active board never change from 0.

Test Plan:
- Reset with all inputs 0 -> defuse_arr==0, busy=0, done=0, mine_hit=0.
- board_dim=8, mine at 1-based (3,3), start (3,3) -> done and mine_hit both at N+2, defuse_arr stays 0.
- board_dim=8, single mine at (1,1), start (2,2) (count 1) -> only bit 1*16+1 set, done at N+4. Repeating the same start -> done at N+2, no change.
- board_dim=8, no mines, start (5,5) -> exactly the 64 bits with x,y<8 set, done at N+579 (K=64, Z=64), busy high N+1..N+578.
- board_dim=10, mines forming a full wall at column 5 (1-based), start (1,1) -> columns 1-4 defused (40 bits), column 5 and beyond stay 0, mine_hit=0.
- board_dim=16, no mines, start (16,16); assert start again at N+10 and clear at N+20 -> second start ignored, defuse_arr==0 and busy=0 at N+21, no done pulse. A new start (1,1) afterwards floods all 256 fields.
